// File: rtl/address_high_unit.sv
// Address-high unit: prioritised source mux onto the ADH bus with split
// zero-forcing, a registered address-high (ABH), and a one-cycle page-cross
// fix-up (ABH +/- 1) that raises fix_busy while it is in progress.
module address_high_unit #(
  parameter int DATA_W    = 8,
  parameter int NUM_SRC   = 4,
  parameter int ZERO_LO_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_sel,
  input  logic                        zero_lo,
  input  logic                        zero_hi,
  input  logic                        ld,
  input  logic                        fix_req,
  input  logic                        fix_dec,
  output logic [DATA_W-1:0]           adh,
  output logic [DATA_W-1:0]           abh,
  output logic                        fix_busy,
  output logic                        sel_conflict
);

  // Bits covered by zero_lo; the complement is covered by zero_hi.
  localparam logic [DATA_W-1:0] LO_MASK = {{(DATA_W-ZERO_LO_W){1'b0}}, {ZERO_LO_W{1'b1}}};

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   abh_q, abh_d;
  logic                dir_q, dir_d;
  logic                fix_busy_q, fix_busy_d;
  logic                sel_conflict_q, sel_conflict_d;

  logic [DATA_W-1:0]   sel_data;
  logic                sel_found;
  logic                multi_sel;

  // Lowest-index asserted enable wins; with no enable the bus stays at zero,
  // so an unselected (possibly unknown) source can never leak through.
  always_comb begin
    sel_data  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel[i] && !sel_found) begin
        sel_data  = src_data[i*DATA_W +: DATA_W];
        sel_found = 1'b1;
      end
    end
  end

  // Zero-forcing of the low and high bit fields, applied after selection.
  always_comb begin
    adh = sel_data;
    if (zero_lo) begin
      adh = adh & ~LO_MASK;
    end
    if (zero_hi) begin
      adh = adh & LO_MASK;
    end
  end

  // Clearing the lowest set bit leaves something behind only if two or more
  // enables are high at once.
  assign multi_sel = |(src_sel & (src_sel - NUM_SRC'(1)));

  // Next-state logic: load/fix-up request handling in IDLE, the single
  // increment/decrement step in FIX, and the sticky conflict flag.
  always_comb begin
    state_d        = state_q;
    abh_d          = abh_q;
    dir_d          = dir_q;
    sel_conflict_d = sel_conflict_q | multi_sel;

    case (state_q)
      IDLE: begin
        if (ld) begin
          abh_d = adh;
        end
        if (fix_req) begin
          state_d = FIX;
          dir_d   = fix_dec;
        end
      end
      FIX: begin
        if (dir_q) begin
          abh_d = abh_q - DATA_W'(1);
        end else begin
          abh_d = abh_q + DATA_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fix_busy_d = (state_d == FIX);
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      abh_q          <= '0;
      dir_q          <= 1'b0;
      fix_busy_q     <= 1'b0;
      sel_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      abh_q          <= abh_d;
      dir_q          <= dir_d;
      fix_busy_q     <= fix_busy_d;
      sel_conflict_q <= sel_conflict_d;
    end
  end

  assign abh          = abh_q;
  assign fix_busy     = fix_busy_q;
  assign sel_conflict = sel_conflict_q;

endmodule

// File: tb/tb_address_high_unit.sv
// Self-checking bench for address_high_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_address_high_unit;

  localparam int DATA_W    = 8;
  localparam int NUM_SRC   = 4;
  localparam int ZERO_LO_W = 1;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_sel;
  logic                      zero_lo;
  logic                      zero_hi;
  logic                      ld;
  logic                      fix_req;
  logic                      fix_dec;
  logic [DATA_W-1:0]         adh;
  logic [DATA_W-1:0]         abh;
  logic                      fix_busy;
  logic                      sel_conflict;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Behavioural model state
  int m_abh;
  bit m_in_fix;
  bit m_dir;
  bit m_conflict;

  address_high_unit #(
    .DATA_W(DATA_W),
    .NUM_SRC(NUM_SRC),
    .ZERO_LO_W(ZERO_LO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_data(src_data),
    .src_sel(src_sel),
    .zero_lo(zero_lo),
    .zero_hi(zero_hi),
    .ld(ld),
    .fix_req(fix_req),
    .fix_dec(fix_dec),
    .adh(adh),
    .abh(abh),
    .fix_busy(fix_busy),
    .sel_conflict(sel_conflict)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Expected ADH from the current inputs: first enabled source by index,
  // then clear each bit whose field has its zero control asserted.
  function automatic int model_adh();
    int idx;
    int v;
    idx = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_sel[i]) idx = i;
    end
    v = 0;
    if (idx >= 0) v = int'((src_data >> (DATA_W * idx)) & 32'hFF);
    for (int b = 0; b < DATA_W; b++) begin
      if ((b < ZERO_LO_W) ? zero_lo : zero_hi) v = v & ~(1 << b);
    end
    return v;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_abh      = 0;
      m_in_fix   = 0;
      m_dir      = 0;
      m_conflict = 0;
    end else begin
      if ($countones(src_sel) >= 2) m_conflict = 1;
      if (m_in_fix) begin
        m_abh    = (m_abh + (m_dir ? 255 : 1)) % 256;
        m_in_fix = 0;
      end else begin
        if (ld) m_abh = model_adh();
        if (fix_req) begin
          m_in_fix = 1;
          m_dir    = fix_dec;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      check_output("adh", int'(adh), model_adh());
      check_output("abh", int'(abh), m_abh);
      check_output("fix_busy", int'(fix_busy), int'(m_in_fix));
      check_output("sel_conflict", int'(sel_conflict), int'(m_conflict));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NUM_SRC-1:0] sel, input logic [DATA_W-1:0] s0,
                                input logic zl, input logic zh, input logic l,
                                input logic fr, input logic fd);
    src_sel  = sel;
    src_data[DATA_W-1:0] = s0;
    zero_lo  = zl;
    zero_hi  = zh;
    ld       = l;
    fix_req  = fr;
    fix_dec  = fd;
  endtask

  initial begin
    rst_n    = 0;
    src_data = '0;
    src_sel  = '0;
    zero_lo  = 0;
    zero_hi  = 0;
    ld       = 0;
    fix_req  = 0;
    fix_dec  = 0;
    repeat (2) step();

    // Reset state
    check_output("reset_abh", int'(abh), 0);
    check_output("reset_busy", int'(fix_busy), 0);
    check_output("reset_conflict", int'(sel_conflict), 0);
    rst_n    = 1;
    checking = 1;

    // Priority with conflicting enables; sticky conflict until reset
    src_data = 32'h44332211;
    src_sel  = 4'b0110;
    #1;
    check_output("prio_adh", int'(adh), 8'h22);
    step();
    check_output("conflict_set", int'(sel_conflict), 1);
    src_sel = 4'b0001;
    repeat (3) step();
    check_output("conflict_sticky", int'(sel_conflict), 1);
    rst_n = 0;
    step();
    check_output("conflict_cleared", int'(sel_conflict), 0);
    rst_n = 1;

    // Zero-forcing
    src_sel = 4'b0001;
    zero_lo = 1; #1;
    check_output("zero_lo", int'(adh), 8'h10);
    zero_lo = 0; zero_hi = 1; #1;
    check_output("zero_hi", int'(adh), 8'h01);
    zero_lo = 1; #1;
    check_output("zero_both", int'(adh), 8'h00);
    zero_lo = 0; zero_hi = 0; src_sel = 4'b0000; #1;
    check_output("no_sel", int'(adh), 8'h00);
    step();

    // Page-cross: load and fix-up in the same cycle
    apply_stimulus(4'b0001, 8'h12, 0, 0, 1, 1, 0);
    step();
    apply_stimulus(4'b0001, 8'h12, 0, 0, 0, 0, 0);
    check_output("pc_abh_load", int'(abh), 8'h12);
    check_output("pc_busy", int'(fix_busy), 1);
    step();
    check_output("pc_abh_fix", int'(abh), 8'h13);
    check_output("pc_busy_done", int'(fix_busy), 0);

    // Wrap-around in both directions
    apply_stimulus(4'b0001, 8'hFF, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(4'b0001, 8'hFF, 0, 0, 0, 1, 0);
    step();
    apply_stimulus(4'b0001, 8'hFF, 0, 0, 0, 0, 0);
    step();
    check_output("wrap_up", int'(abh), 8'h00);
    apply_stimulus(4'b0001, 8'hFF, 0, 0, 0, 1, 1);
    step();
    apply_stimulus(4'b0001, 8'hFF, 0, 0, 0, 0, 0);
    step();
    check_output("wrap_down", int'(abh), 8'hFF);

    // Requests during FIX are ignored
    apply_stimulus(4'b0001, 8'h40, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(4'b0001, 8'h40, 0, 0, 0, 1, 0);
    step();
    apply_stimulus(4'b0001, 8'h55, 0, 0, 1, 1, 1);
    step();
    apply_stimulus(4'b0001, 8'h55, 0, 0, 0, 0, 0);
    check_output("ign_abh", int'(abh), 8'h41);
    check_output("ign_busy", int'(fix_busy), 0);
    step();
    check_output("ign_abh_hold", int'(abh), 8'h41);
    check_output("ign_single_fix", int'(fix_busy), 0);

    // Reset during FIX abandons the fix-up
    apply_stimulus(4'b0001, 8'h80, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(4'b0001, 8'h80, 0, 0, 0, 1, 0);
    step();
    apply_stimulus(4'b0001, 8'h80, 0, 0, 0, 0, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    check_output("rstfix_abh", int'(abh), 0);
    check_output("rstfix_busy", int'(fix_busy), 0);
    apply_stimulus(4'b0001, 8'h80, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(4'b0001, 8'h80, 0, 0, 0, 0, 0);
    check_output("rstfix_reload", int'(abh), 8'h80);
    step();
    check_output("rstfix_idle", int'(fix_busy), 0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      src_data = $urandom;
      if ($urandom_range(0, 7) != 0) src_sel = NUM_SRC'(1 << $urandom_range(0, NUM_SRC - 1));
      else src_sel = NUM_SRC'($urandom);
      zero_lo = ($urandom_range(0, 3) == 0);
      zero_hi = ($urandom_range(0, 3) == 0);
      ld      = $urandom_range(0, 1);
      fix_req = ($urandom_range(0, 2) == 0);
      fix_dec = $urandom_range(0, 1);
      rst_n   = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n = 1;
    step();
    checking = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/address_high_unit.md
Name: address_high_unit

Overview:
- Parametrised successor to the CPU's address-high bus mux.
- Selects one of NUM_SRC byte sources onto the ADH bus, with split zero-forcing applied to the low and high bit fields.
- Latches ADH into a registered address-high output (ABH).
- Performs the one-cycle page-cross fix-up (ABH ±1) used by indexed and relative addressing, with a busy indication so the timing sequencer can insert the extra cycle.

Parameters:
DATA_W, 8, width of the bus and of every source.
NUM_SRC, 4, number of selectable sources; index 0 has the highest priority.
ZERO_LO_W, 1, number of LSBs forced to zero by zero_lo; the remaining DATA_W-ZERO_LO_W MSBs are forced by zero_hi. Legal range 1..DATA_W-1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
src_data  in  NUM_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W].
src_sel  in  NUM_SRC  source enables, one bit per source.
zero_lo  in  1  force ADH[ZERO_LO_W-1:0] to 0.
zero_hi  in  1  force ADH[DATA_W-1:ZERO_LO_W] to 0.
ld  in  1  load ABH from ADH.
fix_req  in  1  request a page-cross fix-up.
fix_dec  in  1  fix-up direction: 0 = +1, 1 = -1; sampled together with fix_req.
adh  out  DATA_W  combinational ADH bus value.
abh  out  DATA_W  registered address-high.
fix_busy  out  1  high during the FIX cycle.
sel_conflict  out  1  sticky flag: more than one src_sel bit was seen high.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- ADH bus (combinational, zero latency):
  - The lowest-index asserted src_sel bit selects its source.
  - If no src_sel bit is set, the bus is all zeros.
  - zero_lo and zero_hi are applied after selection and are independent. Both set gives 0.
- State machine: states IDLE and FIX. Reset enters IDLE.
- IDLE:
  - If ld=1: abh <= adh on the next edge.
  - If fix_req=1: go to FIX. Latch fix_dec into an internal direction register.
  - ld and fix_req together: the load happens on this edge, and the fix-up then applies to the freshly loaded value. This is the page-cross case.
  - fix_req alone: the fix-up applies to the current abh.
- FIX (exactly one cycle):
  - fix_busy=1.
  - On the exiting edge: abh <= abh+1 or abh-1 modulo 2^DATA_W. 0xFF+1 wraps to 0x00 and 0x00-1 wraps to 0xFF, with no carry out.
  - ld and fix_req are ignored in FIX. Requests are not queued. FIX always returns to IDLE.
- fix_busy is a registered state decode and equals 1 only while in FIX.
- sel_conflict:
  - Set on any edge where two or more src_sel bits are high, including during FIX.
  - Stays set until reset. Does not alter mux priority.
- Reset values: abh=0, fix_busy=0, sel_conflict=0, state=IDLE, direction register=0. adh is combinational and carries no reset value.
- Reset mid-FIX: the pending fix-up is abandoned. abh=0 on the following cycle.
- Reset has priority over ld and fix_req on the same edge.
- No X propagation: an unselected or unknown source never reaches abh when src_sel is all zeros.

Test Plan:
1. DATA_W=8, src_data={0x44,0x33,0x22,0x11}, src_sel=4'b0110 -> adh=0x22 (source 1 wins), and sel_conflict=1 after the edge and stays 1 until rst_n=0.
2. src_sel=4'b0001 (0x11), zero_lo=1 -> adh=0x10; zero_hi=1 only -> adh=0x01; both -> 0x00; src_sel=0 -> 0x00.
3. Source 0 = 0x12, ld=1 and fix_req=1 (fix_dec=0) in the same cycle -> next cycle abh=0x12 and fix_busy=1; the cycle after, abh=0x13 and fix_busy=0.
4. Wrap-around: abh=0xFF, fix_req=1 with fix_dec=0 -> abh=0x00 after FIX. abh=0x00, fix_dec=1 -> abh=0xFF.
5. During the FIX cycle drive ld=1 with adh=0x55 and fix_req=1 -> both ignored. abh ends at the fix-up result, a single FIX cycle only, and back in IDLE.
6. Start a fix-up from abh=0x80 and assert rst_n=0 in the FIX cycle -> next cycle abh=0x00, fix_busy=0, state IDLE. A following ld of 0x80 then loads normally.
